// File: rtl/alu_exec_unit.sv
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execute stage with single-cycle logic/arith ops and an
//                iterative shift-add multiplier, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [AW-1:0]    destadd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic [AW-1:0]    destadd,
    output logic             zero,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] C_OP_ADD  = 4'd0;
    localparam logic [3:0] C_OP_SUB  = 4'd1;
    localparam logic [3:0] C_OP_AND  = 4'd2;
    localparam logic [3:0] C_OP_OR   = 4'd3;
    localparam logic [3:0] C_OP_XOR  = 4'd4;
    localparam logic [3:0] C_OP_SLT  = 4'd5;
    localparam logic [3:0] C_OP_SLTU = 4'd6;
    localparam logic [3:0] C_OP_SLL  = 4'd7;
    localparam logic [3:0] C_OP_SRL  = 4'd8;
    localparam logic [3:0] C_OP_SRA  = 4'd9;
    localparam logic [3:0] C_OP_MUL  = 4'd10;

    localparam logic [SHW-1:0] C_CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_out;
    logic [AW-1:0]    r_destadd;
    logic             r_zero;
    logic             r_illegal;

    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_illegal;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_acc_next;

    assign in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_shamt    = src2[SHW-1:0];
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (op)
            C_OP_ADD:  w_result = src1 + src2;
            C_OP_SUB:  w_result = src1 - src2;
            C_OP_AND:  w_result = src1 & src2;
            C_OP_OR:   w_result = src1 | src2;
            C_OP_XOR:  w_result = src1 ^ src2;
            C_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            C_OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            C_OP_SLL:  w_result = src1 << w_shamt;
            C_OP_SRL:  w_result = src1 >> w_shamt;
            C_OP_SRA:  w_result = $signed(src1) >>> w_shamt;
            C_OP_MUL:  w_result = '0;
            default:   w_illegal = 1'b1;
        endcase
    end

    // Acceptance can occur from IDLE or from DONE when the held result is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_destadd   <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_destadd <= destadd_in;
            if (op == C_OP_MUL) begin
                r_mcand     <= src1;
                r_mplier    <= src2;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
                r_state     <= S_MUL;
            end else begin
                r_alu_out   <= w_result;
                r_zero      <= (w_result == '0);
                r_illegal   <= w_illegal;
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SHW'(1);
                    if (r_cnt == C_CNT_LAST) begin
                        r_alu_out   <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign ALUout     = r_alu_out;
    assign destadd    = r_destadd;
    assign zero       = r_zero;
    assign illegal_op = r_illegal;

endmodule

`default_nettype wire
